// File: rtl/alu_arbiter_pkg.sv
// Shared types, ALU op codes and round-robin helper for the ALU arbiter.
package alu_arbiter_pkg;

  typedef logic [31:0] u32;
  typedef logic [2:0]  u3;
  typedef logic        u1;

  // Upper bound on requesters; sizes the round-robin pointer.
  localparam int unsigned ALU_NREQ_MAX = 4;
  localparam int unsigned PTR_W        = $clog2(ALU_NREQ_MAX);

  // ALUcont encodings.
  localparam u3 ALU_AND  = 3'd0;
  localparam u3 ALU_OR   = 3'd1;
  localparam u3 ALU_ADD  = 3'd2;
  localparam u3 ALU_XOR  = 3'd3;
  localparam u3 ALU_RAND = 3'd4;
  localparam u3 ALU_ROR  = 3'd5;
  localparam u3 ALU_SUB  = 3'd6;
  localparam u3 ALU_SLT  = 3'd7;

  // Operation payload steered onto the shared ALU.
  typedef struct packed {
    u3  op;
    u32 a;
    u32 b;
  } alu_req_t;

  // Idle ALU inputs: AND of zeros, so the idle result is 0.
  localparam alu_req_t ALU_IDLE = '{op: ALU_AND, a: 32'd0, b: 32'd0};

  // Pointer value following a grant to requester idx.
  function automatic logic [PTR_W-1:0] rr_next(input int unsigned idx,
                                                input int unsigned nreq);
    return PTR_W'((idx + 32'd1) % nreq);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU shared by the arbiter's requesters.
//   a, b      : operands
//   alu_cont  : ALU_* op code
//   result_c  : combinational result
//   zero_c    : combinational (result == 0)
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  u32   a,
  input  u32   b,
  input  u3    alu_cont,
  output u32   result_c,
  output logic zero_c
);

  logic [63:0] ror_dbl;
  u32          mix0;
  u32          mix1;
  u32          mix2;

  // Op decode; SLT is a signed compare, ROR rotates by b[4:0].
  always_comb begin
    result_c = '0;
    ror_dbl  = {a, a} >> b[4:0];
    mix0     = a ^ b;
    mix1     = mix0 ^ (mix0 << 13);
    mix2     = mix1 ^ (mix1 >> 17);
    case (alu_cont)
      ALU_AND:  result_c = a & b;
      ALU_OR:   result_c = a | b;
      ALU_ADD:  result_c = a + b;
      ALU_XOR:  result_c = a ^ b;
      ALU_RAND: result_c = mix2 ^ (mix2 << 5);
      ALU_ROR:  result_c = ror_dbl[31:0];
      ALU_SUB:  result_c = a - b;
      ALU_SLT:  result_c = {31'd0, ($signed(a) < $signed(b))};
      default:  result_c = '0;
    endcase
  end

  assign zero_c = (result_c == 32'd0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters,
// with a one-deep registered response slot per requester.
//   clk, resetn  : clock, async active-low reset
//   req_valid    : requester i presents an operation
//   req_ready    : requester i granted this cycle (combinational, one-hot/zero)
//   req_a/b/op   : per-requester operands and ALU op code
//   rsp_valid    : slot i holds a result
//   rsp_ready    : requester i accepts its response
//   rsp_result   : registered ALU result for slot i
//   rsp_zero     : registered ALU zero flag for slot i
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2   // legal range 2..ALU_NREQ_MAX
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  u32   [NREQ-1:0] req_a,
  input  u32   [NREQ-1:0] req_b,
  input  u3    [NREQ-1:0] req_op,
  output logic [NREQ-1:0] rsp_valid,
  input  logic [NREQ-1:0] rsp_ready,
  output u32   [NREQ-1:0] rsp_result,
  output logic [NREQ-1:0] rsp_zero
);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  grant;
  logic             found;
  alu_req_t         alu_in;
  u32               alu_result_c;
  logic             alu_zero_c;

  // A slot accepts new data when empty or being drained this cycle.
  assign elig = req_valid & (~rsp_valid | rsp_ready);

  // Round-robin pick starting at ptr; nothing is granted while in reset.
  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    if (resetn) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          if (!found && (i == (32'(ptr) + k) % NREQ) && elig[i]) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            ptr_nxt  = rr_next(i, NREQ);
          end
        end
      end
    end
  end

  assign req_ready = grant;

  // One-hot steer of the granted operation; idle inputs otherwise.
  always_comb begin
    alu_in = ALU_IDLE;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        alu_in = '{op: req_op[i], a: req_a[i], b: req_b[i]};
      end
    end
  end

  alu_arbiter_alu u_alu (
    .a        (alu_in.a),
    .b        (alu_in.b),
    .alu_cont (alu_in.op),
    .result_c (alu_result_c),
    .zero_c   (alu_zero_c)
  );

  // Response slots and pointer; a refill wins over a same-cycle drain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr        <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_zero   <= '0;
    end else begin
      ptr       <= ptr_nxt;
      rsp_valid <= grant | (rsp_valid & ~rsp_ready);
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          rsp_result[i] <= alu_result_c;
          rsp_zero[i]   <= alu_zero_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a queue-based response scoreboard.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int unsigned NREQ = 2;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
  } exp_t;

  logic                  clk;
  logic                  resetn;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][31:0] req_a;
  logic [NREQ-1:0][31:0] req_b;
  logic [NREQ-1:0][2:0]  req_op;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [NREQ-1:0][31:0] rsp_result;
  logic [NREQ-1:0]       rsp_zero;

  int n_checks;
  int n_err;

  logic [31:0] exp_res [2];
  logic        exp_z   [2];
  exp_t        q0 [$];
  exp_t        q1 [$];

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester obligations: operands stable and valid held until granted.
  for (genvar g = 0; g < NREQ; g++) begin : g_obl
    a_hold: assert property (@(posedge clk) disable iff (!resetn)
      (req_valid[g] && !req_ready[g]) |=>
        (req_valid[g] && $stable(req_a[g]) && $stable(req_b[g]) && $stable(req_op[g])))
      else $error("requester %0d broke the request handshake", g);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic set_req(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [31:0] r, input logic z);
    req_a[s]   = a;
    req_b[s]   = b;
    req_op[s]  = op;
    exp_res[s] = r;
    exp_z[s]   = z;
  endtask

  // One cycle: check the expected grant and queue the expected responses.
  task automatic step(input logic [1:0] exp_rdy, input string name);
    exp_t e;
    @(negedge clk);
    chk(name, 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy[0]) begin
      e.r = exp_res[0]; e.z = exp_z[0];
      q0.push_back(e);
    end
    if (exp_rdy[1]) begin
      e.r = exp_res[1]; e.z = exp_z[1];
      q1.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expected response for slot s and compare.
  task automatic check_rsp(input logic s);
    exp_t e;
    int   sz;
    sz = (s == 1'b0) ? q0.size() : q1.size();
    n_checks++;
    if (sz == 0) begin
      n_err++;
      $display("FAIL rsp%0d_unexpected: actual=%0h required=none", s, rsp_result[s]);
    end else begin
      e = (s == 1'b0) ? q0.pop_front() : q1.pop_front();
      if (rsp_result[s] !== e.r || rsp_zero[s] !== e.z) begin
        n_err++;
        $display("FAIL rsp%0d: actual=%0h/z%0b required=%0h/z%0b",
                 s, rsp_result[s], rsp_zero[s], e.r, e.z);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (rsp_valid[0] && rsp_ready[0]) check_rsp(1'b0);
        if (rsp_valid[1] && rsp_ready[1]) check_rsp(1'b1);
      end
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_err     = 0;
    resetn    = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 2'b11;
    fork
      monitor();
    join_none

    // Async reset with requests already valid.
    set_req(1'b0, 32'd6, 32'd3, ALU_ADD, 32'd9, 1'b0);
    set_req(1'b1, 32'd11, 32'd12, ALU_SLT, 32'd1, 1'b0);
    req_valid = 2'b11;
    #1 resetn = 1'b0;
    #2;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_result0", rsp_result[0], 32'd0);
    chk("rst_result1", rsp_result[1], 32'd0);
    chk("rst_zero", 32'(rsp_zero), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Round-robin after reset: req0 then req1.
    step(2'b01, "rr_first");
    req_valid = 2'b10;
    step(2'b10, "rr_second");

    // Pointer back at 0: req0 wins again; covers AND and SUB zero flag.
    set_req(1'b0, 32'd2, 32'd7, ALU_AND, 32'd2, 1'b0);
    set_req(1'b1, 32'd11, 32'd11, ALU_SUB, 32'd0, 1'b1);
    req_valid = 2'b11;
    step(2'b01, "ptr_wrap_req0");
    req_valid = 2'b10;
    step(2'b10, "ptr_wrap_req1");
    req_valid = 2'b00;
    step(2'b00, "idle");

    // Back-pressure on slot 0.
    rsp_ready = 2'b10;
    set_req(1'b0, 32'd5, 32'd10, ALU_OR, 32'd15, 1'b0);
    req_valid = 2'b01;
    step(2'b01, "bp_fill");
    set_req(1'b0, 32'd8, 32'hffff_fff8, ALU_ROR, 32'h0000_0800, 1'b0);
    set_req(1'b1, 32'd15, 32'd4, ALU_SUB, 32'd11, 1'b0);
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      step(2'b10, "bp_stall");
      chk("bp_hold_result", rsp_result[0], 32'd15);
      chk("bp_hold_valid", 32'(rsp_valid[0]), 32'd1);
    end
    rsp_ready = 2'b11;
    step(2'b01, "bp_release");
    req_valid = 2'b10;
    step(2'b10, "bp_after");
    req_valid = 2'b00;
    step(2'b00, "bp_drain");

    // Drain and refill slot 0 every cycle.
    req_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: set_req(1'b0, 32'd1, 32'd1, ALU_ADD, 32'd2, 1'b0);
        1: set_req(1'b0, 32'hffff_ffff, 32'd1, ALU_ADD, 32'd0, 1'b1);
        2: set_req(1'b0, 32'h8000_0000, 32'd1, ALU_SLT, 32'd1, 1'b0);
        default: set_req(1'b0, 32'd4, 32'd6, ALU_SUB, 32'hffff_fffe, 1'b0);
      endcase
      step(2'b01, "stream");
      chk("stream_valid", 32'(rsp_valid[0]), 32'd1);
    end
    req_valid = 2'b00;
    step(2'b00, "stream_end");
    chk("stream_empty", 32'(rsp_valid[0]), 32'd0);

    // SLT of equal operands gives zero.
    set_req(1'b1, 32'd11, 32'd11, ALU_SLT, 32'd0, 1'b1);
    req_valid = 2'b10;
    step(2'b10, "slt_eq");
    req_valid = 2'b00;
    step(2'b00, "slt_drain");

    // Reset mid-operation with both slots full and requests pending.
    rsp_ready = 2'b00;
    set_req(1'b1, 32'd9, 32'd6, ALU_AND, 32'd0, 1'b1);
    req_valid = 2'b10;
    step(2'b10, "pre_rst1");
    set_req(1'b0, 32'd3, 32'd4, ALU_ADD, 32'd7, 1'b0);
    req_valid = 2'b01;
    step(2'b01, "pre_rst0");
    set_req(1'b0, 32'd1, 32'd2, ALU_ADD, 32'd3, 1'b0);
    set_req(1'b1, 32'd7, 32'd2, ALU_SUB, 32'd5, 1'b0);
    req_valid = 2'b11;
    step(2'b00, "pending");
    chk("full_valid", 32'(rsp_valid), 32'd3);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_result0", rsp_result[0], 32'd0);
    chk("mid_rst_result1", rsp_result[1], 32'd0);
    chk("mid_rst_zero", 32'(rsp_zero), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    rsp_ready = 2'b11;
    resetn    = 1'b1;
    step(2'b01, "post_rst_req0");
    req_valid = 2'b10;
    step(2'b10, "post_rst_req1");
    req_valid = 2'b00;
    step(2'b00, "post_rst_idle");
    step(2'b00, "final_idle");

    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `ALU` between `NREQ` independent requesters, such as the EX stage and a multicycle/debug unit, using a valid/ready request handshake and round-robin arbitration. It registers each granted result and its `zero` flag into a one-deep response slot per requester. A response appears one cycle after grant. Full throughput is one operation per cycle across all requesters.

## Interface
- `NREQ`, default 2: number of requesters, legal range 2..4.
- `clk`  in  1: sole clock, rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `req_valid`  in  `NREQ`: requester i presents an operation.
- `req_ready`  out  `NREQ`: requester i granted this cycle.
- `req_a`  in  `NREQ`×32 (`u32` array): operand A per requester.
- `req_b`  in  `NREQ`×32 (`u32` array): operand B per requester.
- `req_op`  in  `NREQ`×3 (`u3` array): `ALUcont` code per requester, using the `ALU_*` macros.
- `rsp_valid`  out  `NREQ`: response slot i holds a result.
- `rsp_ready`  in  `NREQ`: requester i accepts its response.
- `rsp_result`  out  `NREQ`×32: registered `ALU.result` for slot i.
- `rsp_zero`  out  `NREQ`: registered `ALU.zero` for slot i.

## Operation
- **Eligibility.** Requester i is eligible when `req_valid[i]` is high and its slot can accept data. A slot can accept data when `!rsp_valid[i]`, or when `rsp_valid[i] && rsp_ready[i]` (drain and refill in the same cycle).
- **Grant.**
  - Exactly one eligible requester is granted per cycle, chosen combinationally by round-robin starting at pointer `ptr`.
  - `req_ready` is one-hot or zero, and is never asserted for an ineligible requester.
- **ALU mux.** The granted requester's `req_a`/`req_b`/`req_op` drive the `ALU` instance. With no grant, the ALU inputs are held at 0 and `ALU_AND`, so the idle output is 0.
- **Result capture.** On a grant to i, `rsp_result[i]` and `rsp_zero[i]` are loaded at the next edge and `rsp_valid[i]` is set to 1.
- **Slot clearing.** `rsp_valid[i]` clears on `rsp_valid[i] && rsp_ready[i]` unless slot i is refilled in the same cycle.
- **Pointer update.** After a grant to i, `ptr` becomes `(i+1) mod NREQ`. With no grant, `ptr` is unchanged.
- **Requester obligation.** `req_a`/`req_b`/`req_op` stay stable while `req_valid[i]` is high and `req_ready[i]` is low. `req_valid` may not drop before the grant. The bench checks this with assertions.
- **Datapath widths and op semantics.**
  - All datapath is 32-bit.
  - The arbiter does not interpret the op. The ALU's semantics pass through unchanged, including SLT signed compare, ROR by B[4:0], and RAND.
- **Responses.** Each slot is independent. A stalled slot i (`rsp_ready[i]=0`) blocks only requester i; others continue to be granted.

## Timing
- **Reset** (asynchronous on `resetn` low, effective immediately):
  - `rsp_valid=0`, `rsp_result=0`, `rsp_zero=0`, `ptr=0`.
  - `req_ready` is 0 while in reset.
  - Any in-flight result is discarded.
- **Latency.** Grant in cycle T gives `rsp_valid` high at T+1.
- **Throughput.**
  - One operation per cycle in aggregate.
  - One per cycle per requester only if that requester's response is drained every cycle.
- **Simultaneous events.**
  - Drain and refill of the same slot in one cycle leaves `rsp_valid` at 1 and loads the new result.
  - All requesters valid gives a strictly rotating grant.
- **Output registering.** `rsp_*` are registers. `req_ready` is combinational from `req_valid`, `rsp_valid`, `rsp_ready` and `ptr`; there is no combinational path from operands to outputs.

## Structure
- **`common.svh`:** `u32`/`u3`/`u1`, the `ALU_*` op macros, and a new `ALU_NREQ_MAX` constant (4). Remaining state is just `ptr` plus per-slot registers, so no FSM enum is needed.
- **Sub-modules:** the existing `ALU` module, instantiated once. The round-robin picker is small enough to stay inline.

## Test plan
- **Single op:** requester 0 sends A=2, B=7, `ALU_AND` → `req_ready[0]=1` at T; at T+1 `rsp_valid[0]=1`, `rsp_result[0]=2`, `rsp_zero[0]=0`.
- **Round-robin after reset:** both valid, with req0 = 6 ADD 3 and req1 = 11 SLT 12. Required response:
  - grant req0 at T and req1 at T+1;
  - `rsp_result[0]=9` at T+1 and `rsp_result[1]=1` at T+2;
  - `ptr` returns to 0.
- **Back-pressure:** `rsp_valid[0]=1` with `rsp_ready[0]=0`; req0 issues 8 ROR 32'hfffffff8 → `req_ready[0]` stays 0 and slot 0 holds its old value, while req1 (15 SUB 4) is granted each cycle with result 11. Raising `rsp_ready[0]` grants req0 the same cycle; the next response is 15.
- **Drain+refill:** req0 streams 4 ops with `rsp_ready[0]=1` constantly and req1 idle → one grant per cycle and `rsp_valid[0]` continuously 1 from T+1 to T+4.
- **Zero flag:** 11 SUB 11 → `rsp_result=0`, `rsp_zero=1`. The SLT case 11 SLT 11 → result 0, zero 1.
- **Reset mid-operation:** pull `resetn` low while `rsp_valid=2'b11` and a grant is pending → all `rsp_*` go to 0 immediately without a clock edge. After release, the first grant goes to req0.
